// File: rtl/floor_scheduler_if.sv
// Floor scheduler bus: frame strobe and pause in, floor table and status out.
// Signal prefixes are from the scheduler's point of view.
//   i_frame_clk   : frame strobe, rising edge starts one update
//   i_pause       : skip the update triggered by the current frame edge
//   o_floor_x/y   : left x / top y per slot (slot i at [i])
//   o_floor_valid : bit i high = slot i is on screen
//   o_step/o_level: current per-frame rise and difficulty level
//   o_busy        : high while an update is in flight
//   o_update_done : one-cycle pulse at the end of each update
interface floor_scheduler_if;
  logic             i_frame_clk;
  logic             i_pause;
  logic [4:0][9:0]  o_floor_x;
  logic [4:0][9:0]  o_floor_y;
  logic [4:0]       o_floor_valid;
  logic [2:0]       o_step;
  logic [3:0]       o_level;
  logic             o_busy;
  logic             o_update_done;

  modport master (
    output i_frame_clk, i_pause,
    input  o_floor_x, o_floor_y, o_floor_valid, o_step, o_level, o_busy, o_update_done
  );

  modport slave (
    input  i_frame_clk, i_pause,
    output o_floor_x, o_floor_y, o_floor_valid, o_step, o_level, o_busy, o_update_done
  );
endinterface

// File: rtl/floor_scheduler.sv
// Floor scheduler: on every frame strobe, raises all live floors by the
// current step (retiring those reaching the top), then spawns at most one
// new floor at the bottom at a pseudo-random x, and tracks difficulty.
// Ports:
//   i_clk : system clock, all state changes on its rising edge
//   i_rst : asynchronous active-high reset
//   bus   : floor_scheduler_if slave modport (see interface header)
module floor_scheduler #(
  parameter int          FLOOR_Y_MIN      = 0,
  parameter int          FLOOR_Y_SPAWN    = 459,
  parameter int          X_SPAN           = 550,
  parameter int          MIN_GAP          = 60,
  parameter int          FRAMES_PER_LEVEL = 600,
  parameter int          STEP_MAX         = 4,
  parameter logic [9:0]  LFSR_SEED        = 10'h2A5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  floor_scheduler_if.slave bus
);

  localparam int FC_W = (FRAMES_PER_LEVEL > 1) ? $clog2(FRAMES_PER_LEVEL) : 1;

  // Slot 0 is the rightmost element of each constant.
  localparam logic [4:0][9:0] X_INIT = {10'd140, 10'd190, 10'd50, 10'd80, 10'd60};
  localparam logic [4:0][9:0] Y_INIT = {10'd420, 10'd350, 10'd300, 10'd200, 10'd120};

  typedef enum logic [1:0] {
    S_IDLE,
    S_UPDATE,
    S_SPAWN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [2:0]       r_idx;
  logic [4:0][9:0]  r_x;
  logic [4:0][9:0]  r_y;
  logic [4:0]       r_valid;
  logic [2:0]       r_step;
  logic [3:0]       r_level;
  logic [FC_W-1:0]  r_frame_count;
  logic [9:0]       r_lfsr;
  logic             r_frame_clk_d;
  logic             r_busy;
  logic             r_update_done;

  logic             w_frame_edge;
  logic [9:0]       w_lfsr_next;
  logic [10:0]      w_retire_lim;
  logic [4:0]       w_at_top;
  logic             w_spawn_hit;
  logic [2:0]       w_spawn_idx;
  logic             w_any_valid;
  logic [9:0]       w_max_y;
  logic             w_gap_ok;
  logic [9:0]       w_spawn_x;

  assign w_frame_edge = bus.i_frame_clk & ~r_frame_clk_d;

  // Fibonacci LFSR, taps at bits 10 and 7 (x^10 + x^7 + 1).
  assign w_lfsr_next = {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};

  // Retirement compare is done in 11 bits before any subtraction, so a
  // floor close to the top is retired instead of wrapping past zero.
  assign w_retire_lim = 11'(FLOOR_Y_MIN) + {8'd0, r_step};

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_slot
      assign w_at_top[gi] = ({1'b0, r_y[gi]} <= w_retire_lim);
    end
  endgenerate

  // Spawn target (lowest-index free slot) and lowest live floor (largest y).
  always_comb begin
    w_spawn_hit = 1'b0;
    w_spawn_idx = 3'd0;
    w_any_valid = 1'b0;
    w_max_y     = 10'd0;
    for (int i = 4; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_spawn_hit = 1'b1;
        w_spawn_idx = 3'(i);
      end
    end
    for (int i = 0; i < 5; i++) begin
      if (r_valid[i]) begin
        w_any_valid = 1'b1;
        if (r_y[i] > w_max_y) w_max_y = r_y[i];
      end
    end
  end

  assign w_gap_ok  = !w_any_valid ||
                     (({1'b0, w_max_y} + 11'(MIN_GAP)) <= 11'(FLOOR_Y_SPAWN));
  // LFSR spans 0..1023; one conditional subtract folds it into 0..X_SPAN-1.
  assign w_spawn_x = (r_lfsr < 10'(X_SPAN)) ? r_lfsr : (r_lfsr - 10'(X_SPAN));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_idx         <= 3'd0;
      r_x           <= X_INIT;
      r_y           <= Y_INIT;
      r_valid       <= 5'b11111;
      r_step        <= 3'd1;
      r_level       <= 4'd0;
      r_frame_count <= '0;
      r_lfsr        <= LFSR_SEED;
      r_frame_clk_d <= 1'b0;
      r_busy        <= 1'b0;
      r_update_done <= 1'b0;
    end else begin
      r_lfsr        <= w_lfsr_next;
      r_frame_clk_d <= bus.i_frame_clk;
      r_update_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_frame_edge && !bus.i_pause) begin
            r_state <= S_UPDATE;
            r_idx   <= 3'd0;
            r_busy  <= 1'b1;
          end
        end
        S_UPDATE: begin
          if (r_valid[r_idx]) begin
            if (w_at_top[r_idx]) r_valid[r_idx] <= 1'b0;
            else                 r_y[r_idx]     <= r_y[r_idx] - {7'd0, r_step};
          end
          if (r_idx == 3'd4) r_state <= S_SPAWN;
          else               r_idx   <= r_idx + 3'd1;
        end
        S_SPAWN: begin
          if (w_spawn_hit && w_gap_ok) begin
            r_valid[w_spawn_idx] <= 1'b1;
            r_y[w_spawn_idx]     <= 10'(FLOOR_Y_SPAWN);
            r_x[w_spawn_idx]     <= w_spawn_x;
          end
          r_state       <= S_DONE;
          r_update_done <= 1'b1;
        end
        S_DONE: begin
          if (r_frame_count == FC_W'(FRAMES_PER_LEVEL - 1)) begin
            r_frame_count <= '0;
            if (r_step < 3'(STEP_MAX)) begin
              r_step <= r_step + 3'd1;
              if (r_level != 4'hF) r_level <= r_level + 4'd1;
            end
          end else begin
            r_frame_count <= r_frame_count + 1'b1;
          end
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_floor_x     = r_x;
  assign bus.o_floor_y     = r_y;
  assign bus.o_floor_valid = r_valid;
  assign bus.o_step        = r_step;
  assign bus.o_level       = r_level;
  assign bus.o_busy        = r_busy;
  assign bus.o_update_done = r_update_done;

endmodule

// File: tb/tb_floor_scheduler.sv
module tb_floor_scheduler;
  logic clk;
  logic rst;
  floor_scheduler_if bus ();

  floor_scheduler dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR: x^10 + x^7 + 1, seed 10'h2A5, one shift per clock.
  logic [9:0] m_lfsr;
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 10'h2A5;
    else     m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
  end

  int checks = 0;
  int errors = 0;
  int frames = 0;
  logic [9:0] spawn_lfsr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string pfx);
    int xr[5] = '{60, 80, 50, 190, 140};
    int yr[5] = '{120, 200, 300, 350, 420};
    for (int i = 0; i < 5; i++) begin
      check($sformatf("%s_x%0d", pfx, i), 32'(bus.o_floor_x[i]), 32'(xr[i]));
      check($sformatf("%s_y%0d", pfx, i), 32'(bus.o_floor_y[i]), 32'(yr[i]));
    end
    check({pfx, "_valid"}, 32'(bus.o_floor_valid), 32'h1F);
    check({pfx, "_step"},  32'(bus.o_step), 32'd1);
    check({pfx, "_level"}, 32'(bus.o_level), 32'd0);
    check({pfx, "_busy"},  32'(bus.o_busy), 32'd0);
    check({pfx, "_done"},  32'(bus.o_update_done), 32'd0);
  endtask

  // One unpaused frame; checks update_done latency and captures the LFSR
  // value present during the SPAWN cycle (the cycle before update_done).
  task automatic run_frame();
    int lat;
    logic [9:0] prev;
    lat = 0;
    bus.i_frame_clk = 1'b1;
    @(posedge clk); #1;
    bus.i_frame_clk = 1'b0;
    for (int k = 2; k <= 20 && lat == 0; k++) begin
      prev = m_lfsr;
      @(posedge clk); #1;
      if (bus.o_update_done) begin
        lat = k;
        spawn_lfsr = prev;
      end
    end
    check("latency", 32'(lat), 32'd7);
    @(posedge clk); #1;
    frames++;
    $display("frame %0d done latency=%0d step=%0d level=%0d", frames, lat, bus.o_step, bus.o_level);
  endtask

  initial begin
    bit busy_seen, done_seen;
    int exp_x0;

    rst = 1'b1;
    bus.i_frame_clk = 1'b0;
    bus.i_pause = 1'b0;
    spawn_lfsr = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("rst");
    rst = 1'b0;

    // Idle with no frame strobe: nothing moves.
    repeat (20) @(posedge clk);
    #1;
    check_reset_state("idle");

    // First frame: busy for 7 cycles, update_done in the 7th.
    bus.i_frame_clk = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 1) bus.i_frame_clk = 1'b0;
      check($sformatf("f1_busy_c%0d", k), 32'(bus.o_busy), 32'(k <= 7));
      check($sformatf("f1_done_c%0d", k), 32'(bus.o_update_done), 32'(k == 7));
    end
    frames = 1;
    $display("frame 1 y0=%0d y4=%0d", bus.o_floor_y[0], bus.o_floor_y[4]);
    check("f1_y0", 32'(bus.o_floor_y[0]), 32'd119);
    check("f1_y1", 32'(bus.o_floor_y[1]), 32'd199);
    check("f1_y2", 32'(bus.o_floor_y[2]), 32'd299);
    check("f1_y3", 32'(bus.o_floor_y[3]), 32'd349);
    check("f1_y4", 32'(bus.o_floor_y[4]), 32'd419);
    check("f1_x0", 32'(bus.o_floor_x[0]), 32'd60);
    check("f1_x3", 32'(bus.o_floor_x[3]), 32'd190);
    check("f1_valid", 32'(bus.o_floor_valid), 32'h1F);

    while (frames < 119) run_frame();
    check("f119_y0", 32'(bus.o_floor_y[0]), 32'd1);
    check("f119_valid", 32'(bus.o_floor_valid), 32'h1F);

    // Frame 120: slot 0 retires and is respawned in the same frame.
    run_frame();
    exp_x0 = (spawn_lfsr < 10'd550) ? int'(spawn_lfsr) : int'(spawn_lfsr) - 550;
    check("f120_valid", 32'(bus.o_floor_valid), 32'h1F);
    check("f120_y0", 32'(bus.o_floor_y[0]), 32'd459);
    check("f120_x0", 32'(bus.o_floor_x[0]), 32'(exp_x0));
    check("f120_x0_range", 32'(bus.o_floor_x[0] < 10'd550), 32'd1);
    check("f120_y1", 32'(bus.o_floor_y[1]), 32'd80);
    check("f120_y4", 32'(bus.o_floor_y[4]), 32'd300);

    // Paused frame edge: no activity, nothing changes.
    bus.i_pause = 1'b1;
    bus.i_frame_clk = 1'b1;
    busy_seen = 1'b0;
    done_seen = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 1) bus.i_frame_clk = 1'b0;
      busy_seen |= bus.o_busy;
      done_seen |= bus.o_update_done;
    end
    bus.i_pause = 1'b0;
    $display("paused edge busy_seen=%0d done_seen=%0d", busy_seen, done_seen);
    check("pause_busy", 32'(busy_seen), 32'd0);
    check("pause_done", 32'(done_seen), 32'd0);
    check("pause_y0", 32'(bus.o_floor_y[0]), 32'd459);
    check("pause_y3", 32'(bus.o_floor_y[3]), 32'd230);
    check("pause_x0", 32'(bus.o_floor_x[0]), 32'(exp_x0));
    check("pause_valid", 32'(bus.o_floor_valid), 32'h1F);

    // Difficulty steps; the paused edge must not have counted as a frame.
    while (frames < 599) run_frame();
    check("f599_step", 32'(bus.o_step), 32'd1);
    check("f599_level", 32'(bus.o_level), 32'd0);
    run_frame();
    check("f600_step", 32'(bus.o_step), 32'd2);
    check("f600_level", 32'(bus.o_level), 32'd1);
    while (frames < 1200) run_frame();
    check("f1200_step", 32'(bus.o_step), 32'd3);
    check("f1200_level", 32'(bus.o_level), 32'd2);
    while (frames < 1800) run_frame();
    check("f1800_step", 32'(bus.o_step), 32'd4);
    check("f1800_level", 32'(bus.o_level), 32'd3);
    while (frames < 2400) run_frame();
    check("f2400_step", 32'(bus.o_step), 32'd4);
    check("f2400_level", 32'(bus.o_level), 32'd3);

    // Reset in the middle of an update (slot 2 being processed).
    bus.i_frame_clk = 1'b1;
    @(posedge clk); #1;
    bus.i_frame_clk = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_state("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    done_seen = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      done_seen |= bus.o_update_done;
    end
    $display("after mid-update reset done_seen=%0d", done_seen);
    check("midrst_no_done", 32'(done_seen), 32'd0);
    check_reset_state("midrst_idle");

    frames = 0;
    run_frame();
    check("post_y0", 32'(bus.o_floor_y[0]), 32'd119);
    check("post_y2", 32'(bus.o_floor_y[2]), 32'd299);
    check("post_y4", 32'(bus.o_floor_y[4]), 32'd419);
    check("post_x1", 32'(bus.o_floor_x[1]), 32'd80);
    check("post_valid", 32'(bus.o_floor_valid), 32'h1F);
    check("post_step", 32'(bus.o_step), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
